// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pattern_tx
//  Description : Serialiser for the pattern detector. It takes a WIDTH-bit
//                word through a valid/ready handshake and sends it MSB-first
//                on ser_bit, one bit every STROBE_DIV clocks. ser_en is a
//                one-cycle strobe per bit and connects directly to the
//                receiving shift register's enable. After each frame the
//                line stays silent for GAP_BITS bit periods.
//  Ports       : clk        - system clock, rising edge
//                reset_n    - asynchronous active-low reset
//                in_valid   - in_data holds a word to send
//                in_ready   - block can accept a word this cycle
//                in_data    - word to serialise (WIDTH bits)
//                ser_bit    - serial data, meaningful while ser_en=1
//                ser_en     - one-cycle bit strobe
//                busy       - frame or gap in progress
//                frame_done - one-cycle pulse with the last bit's ser_en
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_tx #(
  parameter int WIDTH      = 8,
  parameter int STROBE_DIV = 4,
  parameter int GAP_BITS   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_bit,
  output logic             ser_en,
  output logic             busy,
  output logic             frame_done
);

  localparam int DIV_W = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STROBE_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  // With no gap the GAP state is unreachable; the constant just stays legal.
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_BITS > 0) ? GAP_W'(GAP_BITS - 1) : '0;
  localparam bit               HAS_GAP  = (GAP_BITS > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic [WIDTH-1:0]   shreg_q,   shreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               div_wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // The handshake outputs depend only on the state register, so they
  // follow an asynchronous reset immediately.
  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign div_wrap = (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ser_bit    = 1'b0;
    ser_en     = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shreg_d   = in_data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        ser_bit   = shreg_q[WIDTH-1];
        div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
        if (div_wrap) begin
          ser_en    = 1'b1;
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST) begin
            frame_done = 1'b1;
            gap_cnt_d  = '0;
            state_d    = HAS_GAP ? ST_GAP : ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        // One gap bit period elapses per div_cnt wrap.
        div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
        if (div_wrap) begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
